// File: rtl/reset_sequencer.sv
// System reset generator behind the PLL: lock filtering, hold window, debounced
// board button, and sticky lock-loss statistics.
module reset_sequencer #(
    parameter int SYNC_STAGES     = 2,
    parameter int LOCK_FILTER     = 4,
    parameter int HOLD_CYCLES     = 16,
    parameter int DEBOUNCE_CYCLES = 1000
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       locked,
    input  logic       button_n,
    input  logic       clear_status,
    output logic       sys_reset,
    output logic       sys_reset_n,
    output logic       running,
    output logic       lock_lost,
    output logic [7:0] loss_count,
    output logic [1:0] fsm_state
);

    localparam int FW = $clog2(LOCK_FILTER + 1);
    localparam int HW = $clog2(HOLD_CYCLES + 1);
    localparam int DW = $clog2(DEBOUNCE_CYCLES + 1);

    localparam logic [FW-1:0] FILT_MAX  = FW'(LOCK_FILTER);
    localparam logic [HW-1:0] HOLD_LAST = HW'(HOLD_CYCLES - 1);
    localparam logic [DW-1:0] DEB_LAST  = DW'(DEBOUNCE_CYCLES - 1);

    localparam logic [1:0] WAIT_LOCK = 2'd0;
    localparam logic [1:0] HOLD      = 2'd1;
    localparam logic [1:0] RUN       = 2'd2;

    if (SYNC_STAGES < 2) begin : g_bad_sync
        $fatal(1, "reset_sequencer: SYNC_STAGES must be at least 2");
    end
    if (LOCK_FILTER < 1) begin : g_bad_filter
        $fatal(1, "reset_sequencer: LOCK_FILTER must be at least 1");
    end
    if (HOLD_CYCLES < 1) begin : g_bad_hold
        $fatal(1, "reset_sequencer: HOLD_CYCLES must be at least 1");
    end
    if (DEBOUNCE_CYCLES < 1) begin : g_bad_debounce
        $fatal(1, "reset_sequencer: DEBOUNCE_CYCLES must be at least 1");
    end

    logic [SYNC_STAGES-1:0] lock_sync;
    logic [SYNC_STAGES-1:0] btn_sync;
    logic                   locked_s;
    logic                   btn_s;

    always_ff @(posedge clock) begin
        if (reset) begin
            lock_sync <= '0;
            btn_sync  <= '0;
        end else begin
            lock_sync <= {lock_sync[SYNC_STAGES-2:0], locked};
            btn_sync  <= {btn_sync[SYNC_STAGES-2:0], button_n};
        end
    end

    assign locked_s = lock_sync[SYNC_STAGES-1];
    assign btn_s    = btn_sync[SYNC_STAGES-1];

    logic [FW-1:0] filt_cnt;
    logic          lock_ok;

    always_ff @(posedge clock) begin
        if (reset) begin
            filt_cnt <= '0;
        end else if (!locked_s) begin
            filt_cnt <= '0;
        end else if (filt_cnt != FILT_MAX) begin
            filt_cnt <= filt_cnt + FW'(1);
        end
    end

    // Gating with locked_s drops lock in the same cycle the synchronized level falls.
    assign lock_ok = locked_s && (filt_cnt == FILT_MAX);

    logic [DW-1:0] deb_cnt;
    logic          btn_level;
    logic          press;

    always_ff @(posedge clock) begin
        if (reset) begin
            deb_cnt   <= '0;
            btn_level <= 1'b1;
        end else if (btn_s == btn_level) begin
            deb_cnt <= '0;
        end else if (deb_cnt == DEB_LAST) begin
            deb_cnt   <= '0;
            btn_level <= btn_s;
        end else begin
            deb_cnt <= deb_cnt + DW'(1);
        end
    end

    assign press = btn_level && !btn_s && (deb_cnt == DEB_LAST);

    logic [1:0]    state;
    logic [1:0]    state_next;
    logic [HW-1:0] hold_cnt;
    logic [HW-1:0] hold_next;
    logic          loss_event;

    always_comb begin
        state_next = state;
        hold_next  = hold_cnt;
        loss_event = 1'b0;
        case (state)
            WAIT_LOCK: begin
                hold_next = '0;
                if (lock_ok) begin
                    state_next = HOLD;
                end
            end
            HOLD: begin
                if (!lock_ok) begin
                    state_next = WAIT_LOCK;
                    hold_next  = '0;
                end else if (press) begin
                    hold_next = '0;
                end else if (hold_cnt == HOLD_LAST) begin
                    state_next = RUN;
                    hold_next  = '0;
                end else begin
                    hold_next = hold_cnt + HW'(1);
                end
            end
            RUN: begin
                hold_next = '0;
                if (!lock_ok) begin
                    state_next = WAIT_LOCK;
                    loss_event = 1'b1;
                end else if (press) begin
                    state_next = HOLD;
                end
            end
            default: begin
                state_next = WAIT_LOCK;
                hold_next  = '0;
            end
        endcase
    end

    // Outputs are registered from the next state so they line up with the state flop.
    always_ff @(posedge clock) begin
        if (reset) begin
            state       <= WAIT_LOCK;
            hold_cnt    <= '0;
            sys_reset   <= 1'b1;
            sys_reset_n <= 1'b0;
        end else begin
            state       <= state_next;
            hold_cnt    <= hold_next;
            sys_reset   <= (state_next != RUN);
            sys_reset_n <= (state_next == RUN);
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            lock_lost  <= 1'b0;
            loss_count <= '0;
        end else if (loss_event) begin
            lock_lost <= 1'b1;
            if (clear_status) begin
                loss_count <= 8'd1;
            end else if (loss_count != 8'hFF) begin
                loss_count <= loss_count + 8'd1;
            end
        end else if (clear_status) begin
            lock_lost  <= 1'b0;
            loss_count <= '0;
        end
    end

    assign running   = (state == RUN);
    assign fsm_state = state;

endmodule

// File: tb/tb_reset_sequencer.sv
// Bench for reset_sequencer: lock-up latency, glitch rejection, lock loss,
// button debounce, loss statistics saturation/clear, and mid-HOLD reset.
module tb_reset_sequencer;

    localparam int SYNC_STAGES     = 2;
    localparam int LOCK_FILTER     = 4;
    localparam int HOLD_CYCLES     = 16;
    localparam int DEBOUNCE_CYCLES = 8;
    localparam int LAT_FALL        = SYNC_STAGES + LOCK_FILTER + HOLD_CYCLES + 1;
    localparam int LAT_RISE        = SYNC_STAGES + 1;

    logic       clock = 1'b0;
    logic       reset;
    logic       locked;
    logic       button_n;
    logic       clear_status;
    logic       sys_reset;
    logic       sys_reset_n;
    logic       running;
    logic       lock_lost;
    logic [7:0] loss_count;
    logic [1:0] fsm_state;

    reset_sequencer #(
        .SYNC_STAGES    (SYNC_STAGES),
        .LOCK_FILTER    (LOCK_FILTER),
        .HOLD_CYCLES    (HOLD_CYCLES),
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) dut (
        .clock       (clock),
        .reset       (reset),
        .locked      (locked),
        .button_n    (button_n),
        .clear_status(clear_status),
        .sys_reset   (sys_reset),
        .sys_reset_n (sys_reset_n),
        .running     (running),
        .lock_lost   (lock_lost),
        .loss_count  (loss_count),
        .fsm_state   (fsm_state)
    );

    // clock / reset
    always #5 clock = ~clock;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout required completion");
        $fatal(1, "watchdog expired");
    end

    int          checks   = 0;
    int          failures = 0;
    logic [31:0] exp_q[$];
    int          exp_loss = 0;
    logic        exp_lost = 1'b0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0d required %0d", tag, got, exp);
        end
    endtask

    task automatic sb_compare(input string tag, input logic [31:0] got);
        logic [31:0] exp;
        exp = (exp_q.size() == 0) ? 32'hFFFF_FFFF : exp_q.pop_front();
        check(tag, got, exp);
    endtask

    // driver tasks
    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic measure_fall(output int n);
        n = 0;
        do begin
            tick();
            n++;
        end while (sys_reset && n < 200);
    endtask

    task automatic check_status(input string tag);
        check({tag, "_loss_count"}, 32'(loss_count), 32'(exp_loss));
        check({tag, "_lock_lost"}, 32'(lock_lost), 32'(exp_lost));
    endtask

    // One-cycle drop of locked while in RUN; optionally clear_status on the loss edge.
    task automatic lock_loss_cycle(input bit with_clear);
        int rise;
        int fall;
        exp_q.push_back(LAT_RISE);
        exp_q.push_back(LAT_FALL);
        locked = 1'b0;
        tick();
        locked = 1'b1;
        rise = 1;
        do begin
            clear_status = with_clear && (rise == LAT_RISE - 1);
            tick();
            rise++;
        end while (!sys_reset && rise < 50);
        clear_status = 1'b0;
        sb_compare("loss_rise_latency", rise);
        exp_lost = 1'b1;
        exp_loss = with_clear ? 1 : ((exp_loss == 255) ? 255 : exp_loss + 1);
        check_status("after_loss");
        fall = rise - 1;
        do begin
            tick();
            fall++;
        end while (sys_reset && fall < 200);
        sb_compare("relock_fall_latency", fall);
    endtask

    task automatic apply_reset();
        reset = 1'b1;
        repeat (3) tick();
        reset = 1'b0;
        exp_loss = 0;
        exp_lost = 1'b0;
    endtask

    initial begin
        int n;
        int hi;

        reset        = 1'b1;
        locked       = 1'b0;
        button_n     = 1'b1;
        clear_status = 1'b0;
        apply_reset();

        check("reset_sys_reset", 32'(sys_reset), 32'd1);
        check("reset_sys_reset_n", 32'(sys_reset_n), 32'd0);
        check("reset_running", 32'(running), 32'd0);
        check("reset_state", 32'(fsm_state), 32'd0);
        check_status("reset");

        // Glitch: three high samples are one short of the filter.
        exp_q.push_back(0);
        locked = 1'b1;
        repeat (3) tick();
        locked = 1'b0;
        hi = 0;
        repeat (12) begin
            tick();
            if (!sys_reset || fsm_state != 2'd0) hi++;
        end
        sb_compare("glitch_left_wait", hi);

        // Lock-up.
        exp_q.push_back(LAT_FALL);
        locked = 1'b1;
        measure_fall(n);
        sb_compare("lockup_fall_latency", n);
        check("lockup_running", 32'(running), 32'd1);
        check("lockup_sys_reset_n", 32'(sys_reset_n), 32'd1);
        check_status("lockup");

        // Lock loss in RUN and reacquire.
        lock_loss_cycle(1'b0);
        check("relock_running", 32'(running), 32'd1);

        // Button bounces shorter than the debounce window.
        exp_q.push_back(0);
        hi = 0;
        repeat (3) begin
            button_n = 1'b0;
            repeat (5) begin
                tick();
                hi += 32'(sys_reset);
            end
            button_n = 1'b1;
            repeat (5) begin
                tick();
                hi += 32'(sys_reset);
            end
        end
        repeat (10) begin
            tick();
            hi += 32'(sys_reset);
        end
        sb_compare("bounce_reset_cycles", hi);

        // Held press: exactly one hold window of reset.
        exp_q.push_back(HOLD_CYCLES);
        hi = 0;
        button_n = 1'b0;
        repeat (20) begin
            tick();
            hi += 32'(sys_reset);
        end
        button_n = 1'b1;
        repeat (40) begin
            tick();
            hi += 32'(sys_reset);
        end
        sb_compare("press_reset_cycles", hi);
        check("press_running", 32'(running), 32'd1);
        check_status("press");

        // Saturation of the loss counter.
        repeat (260) lock_loss_cycle(1'b0);
        check("saturated_loss_count", 32'(loss_count), 32'd255);

        clear_status = 1'b1;
        tick();
        clear_status = 1'b0;
        exp_loss = 0;
        exp_lost = 1'b0;
        check_status("clear");
        check("clear_running", 32'(running), 32'd1);

        lock_loss_cycle(1'b1);
        check("clear_with_loss_count", 32'(loss_count), 32'd1);

        // Reset mid-HOLD (hold_cnt at 10).
        apply_reset();
        repeat (SYNC_STAGES + LOCK_FILTER + 1 + 10) tick();
        check("mid_hold_state", 32'(fsm_state), 32'd1);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("mid_reset_state", 32'(fsm_state), 32'd0);
        check("mid_reset_sys_reset", 32'(sys_reset), 32'd1);
        check("mid_reset_running", 32'(running), 32'd0);
        check_status("mid_reset");
        exp_q.push_back(LAT_FALL);
        measure_fall(n);
        sb_compare("post_reset_fall_latency", n);
        check("post_reset_running", 32'(running), 32'd1);

        check("scoreboard_drained", 32'(exp_q.size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
